muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle CPU datapath, replacing the separate fixed-width `mult` and `div` blocks with one engine. It supports signed and unsigned multiply and divide. A start/busy/done handshake lets the control unit stall exactly until the result is ready. The HI/LO result registers are built in, so the datapath's `Hi_`/`Lo_` registers and the MDSelect muxes are no longer needed.

## Interface
- `WIDTH`, 32: operand width. Must be even and ≥ 4.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request an operation. Sampled only in IDLE.
- `op`, in, 2: operation select.
  - 00 = MULT (signed)
  - 01 = MULTU
  - 10 = DIV (signed)
  - 11 = DIVU
- `a`, in, WIDTH: multiplicand or dividend. Sampled with `start`.
- `b`, in, WIDTH: multiplier or divisor. Sampled with `start`.
- `hi`, out, WIDTH: upper product word, or remainder.
- `lo`, out, WIDTH: lower product word, or quotient.
- `busy`, out, 1: high while an operation is in flight.
- `done`, out, 1: one-cycle pulse in the cycle `hi`/`lo` first show a new result.
- `div_zero`, out, 1: the last accepted division had `b == 0`.

## Operation
- **Reset values:** `hi = lo = 0`, `busy = done = div_zero = 0`, state IDLE, iteration counter 0.
- **FSM states:** IDLE, RUN, FIX.
- **IDLE:**
  - `start=1` with a division and `b == 0`: go to FIX directly (no iterations).
  - `start=1` otherwise: latch `op` and operand magnitudes, clear counter, go to RUN.
  - In signed modes the magnitude is the two's-complement absolute value. `-2^(WIDTH-1)` maps to `2^(WIDTH-1)` unsigned; no overflow.
- **RUN:** exactly WIDTH iterations, one per clock, then go to FIX.
  - Multiply: radix-2 shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. Quotient is WIDTH bits, partial remainder is WIDTH+1 bits.
- **FIX:** one cycle. Apply sign correction, load `hi`/`lo`, pulse `done`, return to IDLE.
- **Multiply result:** {`hi`,`lo`} = full 2·WIDTH product. Negated when signed and the operand signs differ.
- **Divide result:**
  - `lo` = quotient, truncated toward zero. Negated when signed and the signs differ.
  - `hi` = remainder, carrying the sign of the dividend.
  - `-2^(WIDTH-1) / -1` gives `lo = 0x8000…0` (wraps) and `hi = 0`.
- **Divide by zero:** `hi`/`lo` are not modified. `div_zero` is set in FIX.
- **`div_zero` lifetime:** holds its value until the next accepted `start`, which clears it.
- **`start` while `busy`:** ignored. Operands are not re-latched and there is no queueing.
- **Operand stability:** `a`, `b`, `op` may change freely after the start edge.
- **Result hold:** `hi`/`lo` keep the last result until the next FIX (or reset).

## Timing
- **Start edge:** start is accepted at edge E0. `busy` goes high at E0.
- **Normal operation:** RUN covers E1..E(WIDTH). FIX completes at E(WIDTH+1).
  - `hi`/`lo`/`done` update at E(WIDTH+1).
  - `busy` falls at E(WIDTH+1).
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- **Divide by zero:** FIX completes at E1, so latency is 1 cycle.
- **`done` pulse:** high for exactly one cycle. `busy` and `done` are never high together.
- **Back-to-back:** a new `start` may be applied in the `done` cycle and is accepted (the state is IDLE).
- **Reset mid-operation:** immediate return to reset values. The partial result is discarded, and `done` is not pulsed.
- **Combinational paths:** no combinational path from inputs to outputs. All outputs are registered.

## Structure
- **Package `muldiv_pkg`:**
  - `op` encodings: `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - FSM state typedef (IDLE/RUN/FIX).
  - Helper function `is_div(op)`.
- **Sub-module `muldiv_abs` (combinational):** WIDTH-parametrised conditional negate, `out = neg ? -in : in`.
  - Instantiated for the operand magnitudes and for the result correction.
- **Counter width:** `$clog2(WIDTH+1)` bits.

## Test plan
All values assume WIDTH=32.
- **MULT signed:** `a=0xFFFFFFFD` (-3), `b=7` → after 33 cycles `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`, one-cycle `done`.
- **MULTU:** `a=b=0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
- **DIV signed, negative dividend:** `a=-7`, `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- **DIV signed, overflow:** `a=0x80000000`, `b=0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
- **DIVU:** `a=100`, `b=7` → `lo=14`, `hi=2`.
- **Divide by zero:** after a prior result `hi=2`, `lo=14`, issue DIV `a=5`, `b=0` → `done` one cycle later, `div_zero=1`, `hi=2`/`lo=14` unchanged. A following MULTU `3×4` clears `div_zero` and gives `lo=12`.
- **`start` during `busy`:** pulse `start` with new operands at RUN iteration 5 → ignored; the first result is unaffected.
- **Reset mid-RUN:** assert `reset` at iteration 10 → immediately `busy=0`, `hi=lo=0`; no `done`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state constants and small decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of the final result.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  // negate when requested; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude
  always_comb begin
    out = neg ? (~in + 1'b1) : in;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide engine with built-in
// HI/LO result registers and a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic div_q;
  logic dz_q;
  logic qneg_q;
  logic rneg_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;

  logic sgn;
  logic a_neg;
  logic b_neg;
  logic start_dz;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0] psum;
  logic [WIDTH:0] shifted;
  logic q_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // operand sign decode and the divide-by-zero shortcut
  always_comb begin
    sgn      = is_signed(op);
    a_neg    = sgn & a[WIDTH-1];
    b_neg    = sgn & b[WIDTH-1];
    start_dz = is_div(op) && (b == '0);
  end

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in (a),
    .neg(a_neg),
    .out(mag_a)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in (b),
    .neg(b_neg),
    .out(mag_b)
  );

  // one shift-add / shift-subtract step of the datapath
  always_comb begin
    psum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, dvs} : '0);
    shifted = {rem, acc[WIDTH-1]};
    q_ge    = shifted >= {1'b0, dvs};
  end

  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in (acc),
    .neg(qneg_q),
    .out(prod_fix)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .in (acc[WIDTH-1:0]),
    .neg(qneg_q),
    .out(quo_fix)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .in (rem),
    .neg(rneg_q),
    .out(rem_fix)
  );

  // sequencer: accept in IDLE, iterate in RUN, sign-fix and publish in FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      dvs      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            div_q    <= is_div(op);
            dz_q     <= start_dz;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            acc      <= {{WIDTH{1'b0}}, mag_a};
            rem      <= '0;
            dvs      <= mag_b;
            state    <= start_dz ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (div_q) begin
            rem <= q_ge ? WIDTH'(shifted - {1'b0, dvs})
                        : shifted[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], q_ge};
          end else begin
            acc <= {psum, acc[WIDTH-1:1]};
          end
          if (cnt == LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
          if (dz_q) begin
            div_zero <= 1'b1;
          end else if (div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [1:0] op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic busy;
  logic done;
  logic div_zero;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic exp_dz = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {hi, lo} from plain signed/unsigned arithmetic
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    logic [63:0] r;
    sa = $signed({{W{x[W-1]}}, x});
    sb = $signed({{W{y[W-1]}}, y});
    sx = x;
    sy = y;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          r = {32'h0, 32'h8000_0000};
        else
          r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: r = {x % y, x / y};
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [1:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input bit inject);
    logic [63:0] r;
    int lat;
    int explat;
    bit dz;
    dz = o[1] && (y == '0);
    explat = dz ? 1 : W + 1;
    if (!dz) begin
      r = model(o, x, y);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    exp_dz = dz;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    check("busy_at_start", 64'(busy), 64'd1);
    check("done_low_at_start", 64'(done), 64'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      start = (inject && lat == 5);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(explat));
    check("hi", 64'(hi), 64'(exp_hi));
    check("lo", 64'(lo), 64'(exp_lo));
    check("div_zero", 64'(div_zero), 64'(exp_dz));
    check("busy_low_in_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit saw;
    reset = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    check("tp_mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("tp_mult_lo", 64'(lo), 64'hFFFF_FFEB);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("tp_multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("tp_multu_lo", 64'(lo), 64'h1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("tp_div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("tp_div_hi", 64'(hi), 64'hFFFF_FFFF);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("tp_ovf_lo", 64'(lo), 64'h8000_0000);
    check("tp_ovf_hi", 64'(hi), 64'h0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    check("tp_divu_lo", 64'(lo), 64'd14);
    check("tp_divu_hi", 64'(hi), 64'd2);
    do_op(2'b10, 32'd5, 32'd0, 0);
    check("tp_dz_flag", 64'(div_zero), 64'd1);
    check("tp_dz_hi", 64'(hi), 64'd2);
    check("tp_dz_lo", 64'(lo), 64'd14);
    do_op(2'b01, 32'd3, 32'd4, 0);
    check("tp_dz_clear", 64'(div_zero), 64'd0);
    check("tp_3x4", 64'(lo), 64'd12);
    do_op(2'b11, 32'd1000, 32'd9, 1);
    check("tp_busy_ignore_lo", 64'(lo), 64'd111);
    check("tp_busy_ignore_hi", 64'(hi), 64'd1);

    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = $urandom;
    b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw = 1'b1;
    end
    check("no_done_after_reset", 64'(saw), 64'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: x = '0;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: y = '0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'd1;
        3: y = 32'h7FFF_FFFF;
        default: y = $urandom;
      endcase
      do_op(2'($urandom), x, y, 0);
    end

    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
